// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters,
// with a one-entry tagged response buffer on the result side.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [CTRL_WIDTH-1:0] req0_ctrl,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [CTRL_WIDTH-1:0] req1_ctrl,
  output logic [DATA_WIDTH-1:0] alu_bus_A,
  output logic [DATA_WIDTH-1:0] alu_bus_B,
  output logic [CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_bus_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CTRL_WIDTH-1:0] OP_ADD  = CTRL_WIDTH'(4'b0000);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB  = CTRL_WIDTH'(4'b0001);
  localparam logic [CTRL_WIDTH-1:0] OP_SLL  = CTRL_WIDTH'(4'b0010);
  localparam logic [CTRL_WIDTH-1:0] OP_SLT  = CTRL_WIDTH'(4'b0100);
  localparam logic [CTRL_WIDTH-1:0] OP_SLTU = CTRL_WIDTH'(4'b0110);
  localparam logic [CTRL_WIDTH-1:0] OP_XOR  = CTRL_WIDTH'(4'b1000);
  localparam logic [CTRL_WIDTH-1:0] OP_SRL  = CTRL_WIDTH'(4'b1010);
  localparam logic [CTRL_WIDTH-1:0] OP_SRA  = CTRL_WIDTH'(4'b1011);
  localparam logic [CTRL_WIDTH-1:0] OP_AND  = CTRL_WIDTH'(4'b1100);
  localparam logic [CTRL_WIDTH-1:0] OP_OR   = CTRL_WIDTH'(4'b1110);

  state_t                state_q;
  state_t                state_d;
  logic                  last_grant_q;
  logic                  grant0;
  logic                  grant1;
  logic                  can_accept;
  logic                  accept;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  id_q;
  logic                  err_q;

  // Contest goes to whoever did not win last; a lone requester always wins.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign can_accept = (state_q == EMPTY) | rsp_ready;
  assign accept     = can_accept & (grant0 | grant1);

  always_comb begin
    alu_bus_A = '0;
    alu_bus_B = '0;
    alu_ctrl  = '0;
    unique case (1'b1)
      grant0: begin
        alu_bus_A = req0_a;
        alu_bus_B = req0_b;
        alu_ctrl  = req0_ctrl;
      end
      grant1: begin
        alu_bus_A = req1_a;
        alu_bus_B = req1_b;
        alu_ctrl  = req1_ctrl;
      end
      default: begin
        alu_bus_A = '0;
        alu_bus_B = '0;
        alu_ctrl  = '0;
      end
    endcase
  end

  always_comb begin
    illegal = 1'b1;
    unique case (alu_ctrl)
      OP_ADD, OP_SUB, OP_SLL,
      OP_SLT, OP_SLTU, OP_XOR,
      OP_SRL, OP_SRA, OP_AND,
      OP_OR:   illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain and refill on the same edge keeps the buffer FULL.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (accept)         state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid  = (state_q == FULL);
    req0_ready = can_accept & grant0;
    req1_ready = can_accept & grant1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      data_q       <= alu_bus_out;
      id_q         <= grant1;
      err_q        <= illegal;
      last_grant_q <= grant1;
    end
  end

  assign rsp_data = data_q;
  assign rsp_id   = id_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU on the shared bus,
// scoreboard of expected responses, per-scenario directed checks.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [CW-1:0] req0_ctrl, req1_ctrl;
  logic [DW-1:0] alu_bus_A, alu_bus_B, alu_bus_out;
  logic [CW-1:0] alu_ctrl;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DW-1:0] rsp_data;

  int tests;
  int fails;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  rsp_t sb_q[$];

  alu_share_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_bus_A(alu_bus_A), .alu_bus_B(alu_bus_B),
    .alu_ctrl(alu_ctrl), .alu_bus_out(alu_bus_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_alu(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic [CW-1:0] c
  );
    case (c)
      4'b0000: return a + b;
      4'b0001: return b - a;
      4'b0010: return b << a[4:0];
      4'b0100: return {31'b0, $signed(a) < $signed(b)};
      4'b0110: return {31'b0, a < b};
      4'b1000: return a ^ b;
      4'b1010: return b >> a[4:0];
      4'b1011: return $signed(b) >>> a[4:0];
      4'b1100: return a & b;
      4'b1110: return a | b;
      default: return '0;
    endcase
  endfunction

  function automatic logic is_bad(input logic [CW-1:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
      4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1110:
        return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always_comb alu_bus_out = ref_alu(alu_bus_A, alu_bus_B, alu_ctrl);

  always @(negedge rst_n) sb_q.delete();

  // Pop the buffered response before pushing this cycle's accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_pop: response id=%0d data=%h with no expected entry",
                   rsp_id, rsp_data);
        end else begin
          rsp_t e;
          e = sb_q.pop_front();
          if ({rsp_id, rsp_data, rsp_err} !== e) begin
            fails++;
            $display("FAIL sb_rsp: got id=%0d data=%h err=%0d want id=%0d data=%h err=%0d",
                     rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
          end
        end
      end
      if (req0_ready)
        sb_q.push_back({1'b0, ref_alu(req0_a, req0_b, req0_ctrl), is_bad(req0_ctrl)});
      if (req1_ready)
        sb_q.push_back({1'b1, ref_alu(req1_a, req1_b, req1_ctrl), is_bad(req1_ctrl)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_ctrl = 0;
    req1_a = 0; req1_b = 0; req1_ctrl = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rsp_ready = 1;
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rsp_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin
      fails++;
      $display("FAIL reset_rsp: got v=%0d id=%0d d=%h e=%0d want all 0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    tests++;
    if ({req0_ready, req1_ready, alu_bus_A, alu_bus_B, alu_ctrl} !== '0) begin
      fails++;
      $display("FAIL reset_bus: got r0=%0d r1=%0d A=%h B=%h c=%h want all 0",
               req0_ready, req1_ready, alu_bus_A, alu_bus_B, alu_ctrl);
    end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_single_add();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_ctrl = 4'b0000;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10 || alu_bus_A !== 5 || alu_bus_B !== 7) begin
      fails++;
      $display("FAIL add_accept: got r0=%0d r1=%0d A=%0d B=%0d want 1 0 5 7",
               req0_ready, req1_ready, alu_bus_A, alu_bus_B);
    end
    step();
    req0_valid = 0;
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b0, 32'd12, 1'b0}) begin
      fails++;
      $display("FAIL add_rsp: got v=%0d id=%0d d=%0d e=%0d want 1 0 12 0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    step();
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_drain: got rsp_valid=%0d want 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req0_a = 1; req0_b = 2; req0_ctrl = 4'b0000;
    req1_a = 32'hF0; req1_b = 32'hFF; req1_ctrl = 4'b1000;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      logic w0;
      w0 = (i % 2 == 0);
      @(negedge clk);
      tests++;
      if (req0_ready !== w0 || req1_ready !== !w0) begin
        fails++;
        $display("FAIL rr_grant%0d: got r0=%0d r1=%0d want r0=%0d r1=%0d",
                 i, req0_ready, req1_ready, w0, !w0);
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (2) step();
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++;
      $display("FAIL rr_idle_fair: got r0=%0d r1=%0d want 1 0",
               req0_ready, req1_ready);
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp_ready = 0;
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_ctrl = 4'b0000;
    step();
    req1_valid = 1; req1_a = 9; req1_b = 4; req1_ctrl = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({req0_ready, req1_ready} !== 2'b00 ||
          {rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b0, 32'd12, 1'b0}) begin
        fails++;
        $display("FAIL bp_stall%0d: got r0=%0d r1=%0d v=%0d id=%0d d=%0d want 0 0 1 0 12",
                 i, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data);
      end
      step();
    end
    rsp_ready = 1;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      fails++;
      $display("FAIL bp_release: got r0=%0d r1=%0d want 0 1",
               req0_ready, req1_ready);
    end
    step();
    idle_inputs();
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'd13}) begin
      fails++;
      $display("FAIL bp_refill: got v=%0d id=%0d d=%0d want 1 1 13",
               rsp_valid, rsp_id, rsp_data);
    end
    step();
  endtask

  task automatic test_sub_sra();
    rsp_ready = 1;
    req1_valid = 1; req1_a = 3; req1_b = 10; req1_ctrl = 4'b0001;
    step();
    req1_a = 4; req1_b = 32'h8000_0000; req1_ctrl = 4'b1011;
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b1, 32'd7, 1'b0}) begin
      fails++;
      $display("FAIL sub: got v=%0d id=%0d d=%h e=%0d want 1 1 7 0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    step();
    idle_inputs();
    @(negedge clk);
    tests++;
    if ({rsp_id, rsp_data} !== {1'b1, 32'hF800_0000}) begin
      fails++;
      $display("FAIL sra: got id=%0d d=%h want 1 f8000000", rsp_id, rsp_data);
    end
    step();
  endtask

  task automatic test_illegal();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_ctrl = 4'b0011;
    @(negedge clk);
    tests++;
    if (req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL ill_accept: got r0=%0d want 1", req0_ready);
    end
    step();
    req0_a = 1; req0_b = 2; req0_ctrl = 4'b1110;
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 32'd0, 1'b1}) begin
      fails++;
      $display("FAIL ill_rsp: got v=%0d d=%h e=%0d want 1 0 1",
               rsp_valid, rsp_data, rsp_err);
    end
    step();
    idle_inputs();
    @(negedge clk);
    tests++;
    if ({rsp_data, rsp_err} !== {32'd3, 1'b0}) begin
      fails++;
      $display("FAIL ill_clear: got d=%h e=%0d want 3 0", rsp_data, rsp_err);
    end
    step();
  endtask

  task automatic test_async_reset();
    rsp_ready = 0;
    req1_valid = 1; req1_a = 2; req1_b = 3; req1_ctrl = 4'b0000;
    step();
    idle_inputs();
    #2;
    rst_n = 0;
    #1;
    tests++;
    if ({rsp_valid, rsp_id, rsp_data} !== '0) begin
      fails++;
      $display("FAIL async_rst: got v=%0d id=%0d d=%h want 0 0 0",
               rsp_valid, rsp_id, rsp_data);
    end
    step();
    rst_n = 1;
    rsp_ready = 1;
    step();
    req0_valid = 1; req1_valid = 1;
    req0_a = 6; req0_b = 6; req1_a = 8; req1_b = 8;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++;
      $display("FAIL rst_first: got r0=%0d r1=%0d want 1 0",
               req0_ready, req1_ready);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_drain();
    idle_inputs();
    rsp_ready = 1;
    repeat (3) step();
    tests++;
    if (sb_q.size() != 0 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain: got pending=%0d v=%0d want 0 0",
               sb_q.size(), rsp_valid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_sub_sra();
    test_illegal();
    test_async_reset();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
